// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared state encoding and width helper for the UART transmit arbiter
package uart_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT_DONE} arb_state_t;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_START     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   function automatic int gid_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmit handshake bundle
interface uart_tx_arbiter_if
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   localparam int GW = gid_w(NUM_REQ);

   logic [NUM_REQ-1:0]           Req;
   logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
   logic [NUM_REQ-1:0]           Ack;
   logic [NUM_REQ-1:0]           Done;
   logic                         Err;
   logic [GW-1:0]                Grant_Id;
   logic                         Arb_Busy;
   logic [DATA_BITS-1:0]         Tx_Data;
   logic                         Transmit_Start;
   logic                         Tx_Busy;
   logic                         CTS;
   logic                         BIST_Busy;

   modport master (
      input  Req, Req_Data, Tx_Busy, CTS, BIST_Busy,
      output Ack, Done, Err, Grant_Id, Arb_Busy, Tx_Data, Transmit_Start
   );

   modport slave (
      output Req, Req_Data, Tx_Busy, CTS, BIST_Busy,
      input  Ack, Done, Err, Grant_Id, Arb_Busy, Tx_Data, Transmit_Start
   );

endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotating-priority picker starting at ptr_i
module uart_rr_pick
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GW      = gid_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [GW-1:0]      ptr_i,
   output logic               valid_o,
   output logic [GW-1:0]      winner_o
);

   logic [GW-1:0] idx;

   // Scan from the farthest offset down so the closest requester to ptr_i wins.
   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      idx      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = GW'((int'(ptr_i) + k) % NUM_REQ);
         if (req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ requesters
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int DATA_BITS     = 8,
   parameter int START_TIMEOUT = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   uart_tx_arbiter_if.master bus
);

   localparam int GW = gid_w(NUM_REQ);
   localparam int CW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic [GW-1:0]        ptr_q, ptr_d, gid_q, gid_d;
   logic [GW-1:0]        pick_id, gid_next;
   logic                 pick_valid;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d, done_q, done_d;
   logic                 start_q, start_d, err_q, err_d, busy_q;
   logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_bytes[i] = bus.Req_Data[i*DATA_BITS +: DATA_BITS];
      end
   end

   uart_rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
      .req_i    (bus.Req),
      .ptr_i    (ptr_q),
      .valid_o  (pick_valid),
      .winner_o (pick_id)
   );

   assign gid_next = (gid_q == GW'(NUM_REQ - 1)) ? '0 : gid_q + GW'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      start_d = start_q;
      ack_d   = '0;
      done_d  = '0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid && bus.CTS && !bus.BIST_Busy && !bus.Tx_Busy) begin
               ack_d   = NUM_REQ'(1) << pick_id;
               gid_d   = pick_id;
               data_d  = req_bytes[pick_id];
               start_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bus.Tx_Busy) begin
               start_d = 1'b0;
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               // The UART never acknowledged; give up and move fairness past this requester.
               start_d = 1'b0;
               err_d   = 1'b1;
               ptr_d   = gid_next;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.Tx_Busy) begin
               done_d  = NUM_REQ'(1) << gid_q;
               ptr_d   = gid_next;
               state_d = ST_IDLE;
            end
         end
         default: begin
            start_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         start_q <= start_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign bus.Ack            = ack_q;
   assign bus.Done           = done_q;
   assign bus.Err            = err_q;
   assign bus.Grant_Id       = gid_q;
   assign bus.Arb_Busy       = busy_q;
   assign bus.Tx_Data        = data_q;
   assign bus.Transmit_Start = start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
   import uart_ctrl_pkg::*;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int ST = 16;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   always #5 Clk = ~Clk;

   uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_BITS(DB)) bus ();

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .START_TIMEOUT(ST)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   int errs   = 0;
   int checks = 0;

   // Transaction-level model of the arbiter
   bit           m_idle, m_busy_seen;
   int           m_ptr, m_gid, m_edges;
   logic [DB-1:0] m_data;
   logic [N-1:0] exp_ack, exp_done;
   bit           exp_err, exp_start;

   // UART responder model
   int u_st, u_cnt;
   bit u_ignore_all, u_rand_ignore;

   typedef struct {
      logic [N-1:0]  req;
      bit            cts;
      bit            bist;
      bit            busy;
      logic [N-1:0]  exp_ack;
      logic [DB-1:0] exp_data;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_winner(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_idle = 1; m_busy_seen = 0; m_ptr = 0; m_gid = 0; m_edges = 0; m_data = '0;
      exp_ack = '0; exp_done = '0; exp_err = 0; exp_start = 0;
      u_st = 0; u_cnt = 0;
   endtask

   task automatic cycle();
      logic [N-1:0]    s_req;
      logic [N*DB-1:0] s_data;
      bit              s_cts, s_bist, s_busy;
      int              w;
      s_req = bus.Req; s_data = bus.Req_Data; s_cts = bus.CTS;
      s_bist = bus.BIST_Busy; s_busy = bus.Tx_Busy;
      @(negedge Clk);
      exp_ack = '0; exp_done = '0; exp_err = 0;
      if (m_idle) begin
         w = rr_winner(s_req, m_ptr);
         if (w >= 0 && s_cts && !s_bist && !s_busy) begin
            exp_ack[w] = 1'b1; m_gid = w; m_data = s_data[w*DB +: DB];
            m_idle = 0; m_busy_seen = 0; m_edges = 0;
         end
      end else if (!m_busy_seen) begin
         if (s_busy) m_busy_seen = 1;
         else begin
            m_edges++;
            if (m_edges == ST) begin
               exp_err = 1; m_ptr = (m_gid + 1) % N; m_idle = 1;
            end
         end
      end else if (!s_busy) begin
         exp_done[m_gid] = 1'b1; m_ptr = (m_gid + 1) % N; m_idle = 1;
      end
      exp_start = !m_idle && !m_busy_seen;
      chk("Ack",            32'(bus.Ack),            32'(exp_ack));
      chk("Done",           32'(bus.Done),           32'(exp_done));
      chk("Err",            32'(bus.Err),            32'(exp_err));
      chk("Transmit_Start", 32'(bus.Transmit_Start), 32'(exp_start));
      chk("Arb_Busy",       32'(bus.Arb_Busy),       32'(!m_idle));
      chk("Grant_Id",       32'(bus.Grant_Id),       32'(m_gid));
      chk("Tx_Data",        32'(bus.Tx_Data),        32'(m_data));
      case (u_st)
         0: if (exp_start) begin
               if (u_ignore_all || (u_rand_ignore && $urandom_range(0, 7) == 0)) u_st = 3;
               else begin u_cnt = $urandom_range(0, 3); u_st = 1; end
            end
         1: if (u_cnt == 0) begin bus.Tx_Busy = 1'b1; u_cnt = $urandom_range(1, 5); u_st = 2; end
            else u_cnt--;
         2: if (u_cnt == 0) begin bus.Tx_Busy = 1'b0; u_st = 0; end
            else u_cnt--;
         default: if (!exp_start) u_st = 0;
      endcase
   endtask

   task automatic do_reset();
      Rst = 1'b0;
      bus.Tx_Busy = 1'b0;
      #1;
      chk("rst_Transmit_Start", 32'(bus.Transmit_Start), 0);
      chk("rst_Ack",            32'(bus.Ack),            0);
      chk("rst_Done",           32'(bus.Done),           0);
      chk("rst_Err",            32'(bus.Err),            0);
      chk("rst_Arb_Busy",       32'(bus.Arb_Busy),       0);
      chk("rst_Grant_Id",       32'(bus.Grant_Id),       0);
      chk("rst_Tx_Data",        32'(bus.Tx_Data),        0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      model_reset();
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && !m_idle; i++) cycle();
      chk("drain_idle", 32'(bus.Arb_Busy), 0);
   endtask

   initial begin
      int acks, dones, errc, starts;
      int order [5];
      logic [N-1:0] rq, dbits;

      bus.Req = '0; bus.Req_Data = '0; bus.Tx_Busy = 1'b0;
      bus.CTS = 1'b1; bus.BIST_Busy = 1'b0;
      u_ignore_all = 0; u_rand_ignore = 0;
      model_reset();
      @(negedge Clk);
      do_reset();

      // Single-edge grant decisions from a freshly reset arbiter (ptr = 0)
      tbl[0] = '{4'b1111, 1, 0, 0, 4'b0001, 8'h55};
      tbl[1] = '{4'b0100, 1, 0, 0, 4'b0100, 8'hB2};
      tbl[2] = '{4'b1010, 1, 0, 0, 4'b0010, 8'hA1};
      tbl[3] = '{4'b1000, 1, 0, 0, 4'b1000, 8'hC3};
      tbl[4] = '{4'b0010, 0, 0, 0, 4'b0000, 8'h00};
      tbl[5] = '{4'b0010, 1, 1, 0, 4'b0000, 8'h00};
      tbl[6] = '{4'b0010, 1, 0, 1, 4'b0000, 8'h00};
      tbl[7] = '{4'b0000, 1, 0, 0, 4'b0000, 8'h00};
      for (int t = 0; t < 8; t++) begin
         do_reset();
         bus.Req_Data = {8'hC3, 8'hB2, 8'hA1, 8'h55};
         bus.Req = tbl[t].req; bus.CTS = tbl[t].cts;
         bus.BIST_Busy = tbl[t].bist; bus.Tx_Busy = tbl[t].busy;
         cycle();
         chk("tbl_ack",   32'(bus.Ack),            32'(tbl[t].exp_ack));
         chk("tbl_start", 32'(bus.Transmit_Start), 32'(|tbl[t].exp_ack));
         chk("tbl_data",  32'(bus.Tx_Data),        32'(tbl[t].exp_data));
         bus.Req = '0; bus.CTS = 1'b1; bus.BIST_Busy = 1'b0;
         if (u_st == 0) bus.Tx_Busy = 1'b0;
         drain(100);
      end

      // All requesters held high: strict rotation 0,1,2,3,0
      do_reset();
      bus.Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.Req = 4'b1111;
      acks = 0; dones = 0; errc = 0;
      for (int i = 0; i < 400 && acks < 5; i++) begin
         cycle();
         for (int b = 0; b < N; b++) if (bus.Ack[b]) begin order[acks] = b; acks++; end
         dones += $countones(bus.Done); errc += int'(bus.Err);
      end
      bus.Req = '0;
      for (int i = 0; i < 100 && !m_idle; i++) begin
         cycle();
         dones += $countones(bus.Done); errc += int'(bus.Err);
      end
      chk("rr_ack_count", acks, 5);
      for (int k = 0; k < 5; k++) chk("rr_order", order[k], k % 4);
      chk("rr_done_count", dones, 5);
      chk("rr_no_err", errc, 0);

      // BIST owns the datapath for 50 cycles
      do_reset();
      bus.Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
      bus.Req = 4'b0100; bus.BIST_Busy = 1'b1;
      acks = 0;
      for (int i = 0; i < 50; i++) begin cycle(); acks += $countones(bus.Ack); end
      chk("bist_no_ack", acks, 0);
      bus.BIST_Busy = 1'b0;
      cycle();
      chk("bist_ack2", 32'(bus.Ack), 32'(4'b0100));
      bus.Req = '0;
      drain(100);

      // UART never answers: 16-cycle start window, Err, pointer moves to 3
      do_reset();
      u_ignore_all = 1;
      bus.Req = 4'b0100;
      cycle();
      bus.Req = '0;
      starts = int'(bus.Transmit_Start); errc = 0; dones = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         starts += int'(bus.Transmit_Start); errc += int'(bus.Err);
         dones += $countones(bus.Done);
      end
      chk("to_start_cycles", starts, 16);
      chk("to_err_count", errc, 1);
      chk("to_no_done", dones, 0);
      chk("to_idle", 32'(bus.Arb_Busy), 0);
      u_ignore_all = 0;
      bus.Req = 4'b1111;
      cycle();
      chk("to_ptr_next", 32'(bus.Ack), 32'(4'b1000));
      bus.Req = '0;
      drain(100);

      // CTS gates the grant but not a transfer in flight
      do_reset();
      bus.Req = 4'b0010; bus.CTS = 1'b0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin cycle(); acks += $countones(bus.Ack); end
      chk("cts_no_ack", acks, 0);
      bus.CTS = 1'b1;
      cycle();
      chk("cts_ack1", 32'(bus.Ack), 32'(4'b0010));
      bus.Req = '0;
      dbits = '0;
      for (int i = 0; i < 60 && !m_idle; i++) begin
         cycle();
         if (!m_idle && m_busy_seen) bus.CTS = 1'b0;
         dbits |= bus.Done;
      end
      chk("cts_done1", 32'(dbits), 32'(4'b0010));
      bus.CTS = 1'b1;

      // Reset during START and during WAIT_DONE
      do_reset();
      u_ignore_all = 1;
      bus.Req = 4'b0001;
      cycle(); cycle();
      chk("pre_rst_start", 32'(bus.Transmit_Start), 1);
      do_reset();
      u_ignore_all = 0;
      bus.Req = 4'b1111;
      for (int i = 0; i < 40 && !(m_busy_seen && !m_idle); i++) cycle();
      chk("wait_done_reached", 32'(bus.Arb_Busy && !bus.Transmit_Start), 1);
      do_reset();
      bus.Req = 4'b1111;
      cycle();
      chk("post_rst_ack0", 32'(bus.Ack), 32'(4'b0001));
      bus.Req = '0;
      drain(100);

      // Randomised traffic against the model
      do_reset();
      u_rand_ignore = 1;
      rq = '0; acks = 0; dones = 0; errc = 0;
      for (int i = 0; i < 3000; i++) begin
         bus.CTS = ($urandom_range(0, 9) != 0);
         bus.BIST_Busy = ($urandom_range(0, 19) == 0);
         for (int b = 0; b < N; b++) begin
            if (!rq[b] && $urandom_range(0, 3) == 0) begin
               rq[b] = 1'b1; bus.Req_Data[b*DB +: DB] = DB'($urandom);
            end else if (rq[b] && $urandom_range(0, 49) == 0) begin
               rq[b] = 1'b0;
            end
         end
         bus.Req = rq;
         cycle();
         acks += $countones(bus.Ack); dones += $countones(bus.Done); errc += int'(bus.Err);
         for (int b = 0; b < N; b++) if (exp_ack[b]) begin
            if ($urandom_range(0, 1) == 0) rq[b] = 1'b0;
            else bus.Req_Data[b*DB +: DB] = DB'($urandom);
         end
      end
      bus.Req = '0; bus.CTS = 1'b1; bus.BIST_Busy = 1'b0;
      for (int i = 0; i < 100 && !m_idle; i++) begin
         cycle();
         dones += $countones(bus.Done); errc += int'(bus.Err);
      end
      chk("rand_balance", acks, dones + errc);
      chk("rand_idle", 32'(bus.Arb_Busy), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
